pio_in_capture: RTL and testbench
=================================

// Module: pio_in_capture
// PURPOSE
//  Multi-channel Avalon-MM read-only parallel input port with edge capture, the parametrised successor of the
//  single-word debug PIO inputs on the HPS lightweight bus. Each channel synchronises an asynchronous input word,
//  exposes its live value and latches edges per bit in write-1-to-clear registers. Used by software for
//  boid-engine status/debug words and pushbutton-style event flags without polling races.
// PARAMETERS
//  DATA_W       32  width of each input channel, 1..32
//  NUM_CH       4   number of input channels, 1..16
//  SYNC_STAGES  2   synchroniser flops per input bit, 2..4
//  EDGE_MODE    0   0 = rising, 1 = falling, 2 = any edge latched into edgecapture
//  AW           $clog2(NUM_CH)+2  address width (derived, localparam)
// PORTS
//  clk        in   1               single clock for all logic
//  reset      in   1               reset; synchronous and active-high
//  address    in   AW              word address {channel, offset[1:0]}
//  chipselect in   1               slave select
//  write      in   1               write strobe, qualified by chipselect
//  writedata  in   32              write data
//  readdata   out  32              registered read data
//  in_port    in   NUM_CH*DATA_W   channel ch occupies bits [ch*DATA_W +: DATA_W]; asynchronous to clk
//  irq        out  1               level interrupt (PIO_IN_CAPTURE_IRQ_EN only)
// BEHAVIOUR
//  Reset: readdata=0, irq=0, all sync/prev/edgecapture/irqmask flops=0, prime counter=0.
//  Register map per channel (offset = address[1:0]); bits above DATA_W read 0, writes to them ignored:
//    0 DATA  RO  synchronised input (output of last sync stage); writes ignored
//    1 MASK  RW  irqmask (PIO_IN_CAPTURE_IRQ_EN only; else reads 0, writes ignored)
//    2 EDGE  RW1C edgecapture; writing 1 to bit clears it, 0 leaves it
//    3 RSVD  reads 0, writes ignored
//  Channel index = address[AW-1:2]; index >= NUM_CH reads 0, writes ignored.
//  Read: readdata registered from address mux every clk (latency 1 from address); reads have no side effects.
//  Write takes effect on the clk edge where chipselect && write.
//  Synchroniser: SYNC_STAGES flops per bit; DATA visible SYNC_STAGES cycles after in_port changes.
//  Edge detect: prev <= sync_out each cycle; rise = sync_out & ~prev, fall = ~sync_out & prev, per EDGE_MODE.
//  Prime: counter counts to SYNC_STAGES+1 after reset release; edge detection disabled until it saturates,
//    so a steady-high input at reset never sets edgecapture. Reset mid-operation restarts priming.
//  Simultaneous W1C and new edge on the same bit in the same cycle: edge wins, bit stays 1.
//  Edge on an already-set bit: stays 1 (sticky, no count).
// CONFIGURATION
//  PIO_IN_CAPTURE_IRQ_EN defined: MASK registers implemented; irq <= |(edgecapture & irqmask) over all
//    channels, registered (1 cycle after edgecapture sets, deasserts 1 cycle after last masked bit cleared).
//  Not defined: no MASK flops, irq port absent, MASK offset reads 0.
// STRUCTURE
//  Package pio_in_pkg: offset constants OFF_DATA=0, OFF_MASK=1, OFF_EDGE=2, OFF_RSVD=3; EDGE_RISE/FALL/ANY
//    constants; edge_mode_t enum.
//  Sub-module pio_in_chan (one per channel via generate): sync chain, prev reg, edgecapture, irqmask, W1C;
//    top holds prime counter, address decode, readdata mux, irq OR-reduction.
// TESTING
//  Reset, in_port ch0=32'hFFFF_FFFF held through reset -> DATA0 reads FFFF_FFFF, EDGE0 reads 0 (prime works).
//  Ch2 bit5 0->1 (EDGE_MODE=0) -> DATA2 bit5=1 after 2 clks, EDGE2=32'h20; write EDGE2=32'h20 -> reads 0.
//  Same-cycle W1C of EDGE1 bit0 and new rise on ch1 bit0 -> EDGE1 bit0 reads 1.
//  IRQ_EN: MASK3=1, rise ch3 bit0 -> irq=1 one clk after EDGE3 sets; W1C -> irq=0; MASK3=0 -> no irq.
//  Address channel 5 with NUM_CH=4 -> readdata 0; write ignored (no state change in any channel).
//  DATA_W=8: writedata 32'hFFFF_FFFF to EDGE0 clears only bits[7:0]; readdata[31:8]=0 always.

Source files
------------

// File: rtl/pio_in_pkg.sv
// Shared definitions for the pio_in_capture block.
//   OFF_*        per-channel register offsets (address[1:0])
//   edge_mode_t  edge kinds latched into edgecapture
//   edge_select  picks rise/fall/any edge bits for a given mode
package pio_in_pkg;

    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_EDGE = 2'd2;
    localparam logic [1:0] OFF_RSVD = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_t;

    function automatic logic [31:0] edge_select(input edge_mode_t mode,
                                                input logic [31:0] cur,
                                                input logic [31:0] prev);
        logic [31:0] rise;
        logic [31:0] fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        case (mode)
            EDGE_FALL: return fall;
            EDGE_ANY:  return rise | fall;
            default:   return rise;
        endcase
    endfunction

endpackage

// File: rtl/pio_in_chan.sv
// One input channel: synchroniser chain, previous-value register, sticky
// edgecapture with write-1-to-clear, and optional irqmask.
// Optional feature macro: PIO_IN_CAPTURE_IRQ_EN (adds the irqmask register).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_in           asynchronous input word
//   i_edge_en      edge detection enable (low while priming after reset)
//   i_wr_edge      W1C strobe for edgecapture
//   i_wr_mask      write strobe for irqmask (IRQ build only)
//   i_wdata        write data
//   o_data         synchronised input
//   o_edge         edgecapture
//   o_mask         irqmask (IRQ build only)
module pio_in_chan
    import pio_in_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_in,
    input  logic              i_edge_en,
    input  logic              i_wr_edge,
`ifdef PIO_IN_CAPTURE_IRQ_EN
    input  logic              i_wr_mask,
    output logic [DATA_W-1:0] o_mask,
`endif
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] o_edge
);

    localparam edge_mode_t MODE = edge_mode_t'(EDGE_MODE[1:0]);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_edge;
    logic [31:0]       w_sel;
    logic [DATA_W-1:0] w_new;
    logic [DATA_W-1:0] w_clr;

    assign w_sel = edge_select(MODE, 32'(r_sync[SYNC_STAGES-1]), 32'(r_prev));
    assign w_new = i_edge_en ? w_sel[DATA_W-1:0] : '0;
    assign w_clr = i_wr_edge ? i_wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
            r_edge <= '0;
        end else begin
            r_sync[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
            // a new edge in the same cycle as a clear keeps the bit set
            r_edge <= w_new | (r_edge & ~w_clr);
        end
    end

`ifdef PIO_IN_CAPTURE_IRQ_EN
    logic [DATA_W-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (reset)
            r_mask <= '0;
        else if (i_wr_mask)
            r_mask <= i_wdata;
    end

    assign o_mask = r_mask;
`endif

    assign o_data = r_sync[SYNC_STAGES-1];
    assign o_edge = r_edge;

endmodule

// File: rtl/pio_in_capture.sv
// Multi-channel read-only Avalon-MM parallel input port with per-bit edge
// capture. Holds the post-reset prime counter, address decode, registered
// read mux and the interrupt OR-reduction; channels live in pio_in_chan.
// Optional feature macro: PIO_IN_CAPTURE_IRQ_EN (irqmask registers + irq port).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   address           {channel, offset[1:0]}
//   chipselect/write  write qualified by chipselect
//   writedata         write data
//   readdata          registered read data, latency 1 from address
//   in_port           channel ch at [ch*DATA_W +: DATA_W], asynchronous
//   irq               level interrupt (IRQ build only)
module pio_in_capture
    import pio_in_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int NUM_CH      = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int EDGE_MODE   = 0,
    localparam int AW          = $clog2(NUM_CH) + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AW-1:0]            address,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [31:0]              writedata,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
`ifdef PIO_IN_CAPTURE_IRQ_EN
    output logic                     irq,
`endif
    output logic [31:0]              readdata
);

    localparam int CW        = (AW > 2) ? AW - 2 : 1;
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PW        = $clog2(PRIME_MAX + 1);

    logic [PW-1:0]     r_prime;
    logic              w_edge_en;
    logic [CW-1:0]     w_ch;
    logic              w_ch_ok;
    logic [1:0]        w_off;
    logic              w_wr;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data [NUM_CH];
    logic [DATA_W-1:0] w_edge [NUM_CH];

    // Edge detection stays off until the synchronisers and prev registers
    // have been filled with real input, so levels present at reset are not
    // mistaken for edges.
    always_ff @(posedge clk) begin
        if (reset)
            r_prime <= '0;
        else if (r_prime != PW'(PRIME_MAX))
            r_prime <= r_prime + 1'b1;
    end

    assign w_edge_en = (r_prime == PW'(PRIME_MAX));

    generate
        if (AW > 2) begin : g_ch_idx
            assign w_ch = address[AW-1:2];
        end else begin : g_ch_zero
            assign w_ch = '0;
        end
    endgenerate

    assign w_ch_ok = (32'(w_ch) < NUM_CH);
    assign w_off   = address[1:0];
    assign w_wr    = chipselect && write && w_ch_ok;

`ifdef PIO_IN_CAPTURE_IRQ_EN
    logic [DATA_W-1:0] w_mask [NUM_CH];
    logic              w_irq_any;
`endif

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            logic w_hit;
            assign w_hit = w_wr && (w_ch == CW'(g));

            pio_in_chan #(
                .DATA_W      (DATA_W),
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE_MODE   (EDGE_MODE)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .i_in      (in_port[g*DATA_W +: DATA_W]),
                .i_edge_en (w_edge_en),
                .i_wr_edge (w_hit && (w_off == OFF_EDGE)),
`ifdef PIO_IN_CAPTURE_IRQ_EN
                .i_wr_mask (w_hit && (w_off == OFF_MASK)),
                .o_mask    (w_mask[g]),
`endif
                .i_wdata   (writedata[DATA_W-1:0]),
                .o_data    (w_data[g]),
                .o_edge    (w_edge[g])
            );
        end
    endgenerate

    always_comb begin
        w_rd = '0;
        if (w_ch_ok) begin
            case (w_off)
                OFF_DATA: w_rd = w_data[w_ch];
                OFF_EDGE: w_rd = w_edge[w_ch];
`ifdef PIO_IN_CAPTURE_IRQ_EN
                OFF_MASK: w_rd = w_mask[w_ch];
`endif
                default:  w_rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= 32'(w_rd);
    end

`ifdef PIO_IN_CAPTURE_IRQ_EN
    always_comb begin
        w_irq_any = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            w_irq_any = w_irq_any | (|(w_edge[c] & w_mask[c]));
    end

    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= w_irq_any;
    end
`endif

endmodule

// File: tb/tb_pio_in_capture.sv
// Bench for pio_in_capture: two instances (32-bit x5 rising-edge, and
// 8-bit x2 any-edge with 3 sync stages). Reads push expected values into a
// scoreboard queue; a monitor pops and compares one cycle later.
module tb_pio_in_capture;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   address;
    logic         cs_a, cs_b, write;
    logic [31:0]  writedata;
    logic [159:0] in_a;
    logic [15:0]  in_b;
    logic [31:0]  rd_a, rd_b;
`ifdef PIO_IN_CAPTURE_IRQ_EN
    logic         irq_a, irq_b;
`endif

    always #5 clk = ~clk;

    pio_in_capture #(.DATA_W(32), .NUM_CH(5), .SYNC_STAGES(2), .EDGE_MODE(0)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (address[4:0]),
        .chipselect (cs_a),
        .write      (write),
        .writedata  (writedata),
        .in_port    (in_a),
`ifdef PIO_IN_CAPTURE_IRQ_EN
        .irq        (irq_a),
`endif
        .readdata   (rd_a)
    );

    pio_in_capture #(.DATA_W(8), .NUM_CH(2), .SYNC_STAGES(3), .EDGE_MODE(2)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .address    (address[2:0]),
        .chipselect (cs_b),
        .write      (write),
        .writedata  (writedata),
        .in_port    (in_b),
`ifdef PIO_IN_CAPTURE_IRQ_EN
        .irq        (irq_b),
`endif
        .readdata   (rd_b)
    );

    typedef struct {
        bit          sel;
        logic [31:0] exp;
        string       nm;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    logic [31:0] mon_act;
    int n_chk  = 0;
    int n_fail = 0;
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;

    localparam int DATA = 0, MASK = 1, EDGE = 2, RSVD = 3;
    localparam bit A = 1'b0, B = 1'b1;

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: read completed with no expected entry");
            end else begin
                mon_e   = sb.pop_front();
                mon_act = mon_e.sel ? rd_b : rd_a;
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %08h expected %08h", mon_e.nm, mon_act, mon_e.exp);
                end
            end
        end
    end

    // All tasks start and end at a falling edge.
    task automatic rd(input bit sel, input int ch, input int off,
                      input logic [31:0] exp, input string nm);
        address = 8'((ch << 2) | off);
        write   = 1'b0;
        rd_req  = 1'b1;
        sb.push_back('{sel, exp, nm});
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic wr(input bit sel, input int ch, input int off, input logic [31:0] d);
        address   = 8'((ch << 2) | off);
        writedata = d;
        cs_a      = !sel;
        cs_b      = sel;
        write     = 1'b1;
        @(negedge clk);
        cs_a  = 1'b0;
        cs_b  = 1'b0;
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        address   = '0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        in_a      = '0;
        in_a[31:0] = 32'hFFFF_FFFF;
        in_b      = '0;
        idle(3);

        // reset state
        rd(A, 0, DATA, 32'h0, "reset_readdata");
`ifdef PIO_IN_CAPTURE_IRQ_EN
        chk("reset_irq", irq_a, 1'b0);
`endif
        reset = 1'b0;
        idle(6);
        rd(A, 0, DATA, 32'hFFFF_FFFF, "prime_data0");
        rd(A, 0, EDGE, 32'h0,         "prime_edge0");
        rd(A, 1, DATA, 32'h0,         "data1_idle");
        rd(A, 0, RSVD, 32'h0,         "rsvd0");

        // ch2 bit5 rise: latency of two clocks into DATA, then edge, then W1C
        in_a[2*32+5] = 1'b1;
        rd(A, 2, DATA, 32'h0,  "lat_data2_c0");
        rd(A, 2, DATA, 32'h0,  "lat_data2_c1");
        rd(A, 2, DATA, 32'h20, "lat_data2_c2");
        rd(A, 2, EDGE, 32'h20, "edge2_set");
        rd(A, 2, EDGE, 32'h20, "edge2_read_no_side_effect");
        wr(A, 2, DATA, 32'h0);
        rd(A, 2, DATA, 32'h20, "data2_write_ignored");
        wr(A, 2, EDGE, 32'h20);
        rd(A, 2, EDGE, 32'h0,  "edge2_w1c");

        // ch1 bit0: write-0 keeps, write-1 clears, fall ignored in rise mode
        in_a[32] = 1'b1;
        idle(5);
        rd(A, 1, EDGE, 32'h1, "edge1_set");
        wr(A, 1, EDGE, 32'h0);
        rd(A, 1, EDGE, 32'h1, "edge1_w0_keeps");
        wr(A, 1, EDGE, 32'h1);
        rd(A, 1, EDGE, 32'h0, "edge1_w1c");
        in_a[32] = 1'b0;
        idle(5);
        rd(A, 1, EDGE, 32'h0, "edge1_fall_ignored");

        // rise reaches edgecapture on the same clock as the W1C write
        in_a[32] = 1'b1;
        idle(2);
        wr(A, 1, EDGE, 32'h1);
        rd(A, 1, EDGE, 32'h1, "edge1_edge_beats_w1c");

`ifdef PIO_IN_CAPTURE_IRQ_EN
        wr(A, 3, MASK, 32'h1);
        rd(A, 3, MASK, 32'h1, "mask3_rw");
        chk("irq_idle", irq_a, 1'b0);
        in_a[96] = 1'b1;
        idle(3);
        chk("irq_same_cycle_as_edge", irq_a, 1'b0);
        idle(1);
        chk("irq_set", irq_a, 1'b1);
        wr(A, 3, EDGE, 32'h1);
        chk("irq_hold_after_w1c", irq_a, 1'b1);
        idle(1);
        chk("irq_clear", irq_a, 1'b0);
        wr(A, 3, MASK, 32'h0);
        in_a[97] = 1'b1;
        idle(6);
        chk("irq_masked_off", irq_a, 1'b0);
        rd(A, 3, EDGE, 32'h2, "edge3_unmasked_edge");
`else
        wr(A, 3, MASK, 32'h1);
        rd(A, 3, MASK, 32'h0, "mask3_absent");
`endif

        // out-of-range channel indices
        in_a[4*32+7] = 1'b1;
        idle(5);
        rd(A, 4, EDGE, 32'h80, "edge4_set");
        wr(A, 5, EDGE, 32'hFFFF_FFFF);
        wr(A, 7, EDGE, 32'hFFFF_FFFF);
        wr(A, 5, MASK, 32'hFFFF_FFFF);
        rd(A, 5, DATA, 32'h0,  "ch5_data_zero");
        rd(A, 5, EDGE, 32'h0,  "ch5_edge_zero");
        rd(A, 6, DATA, 32'h0,  "ch6_data_zero");
        rd(A, 4, EDGE, 32'h80, "edge4_untouched");
        rd(A, 1, EDGE, 32'h1,  "edge1_untouched");
        rd(A, 4, DATA, 32'h80, "data4");
`ifdef PIO_IN_CAPTURE_IRQ_EN
        rd(A, 1, MASK, 32'h0,  "mask1_untouched");
`endif

        // 8-bit any-edge instance
        in_b[7:0] = 8'hA5;
        idle(6);
        rd(B, 0, EDGE, 32'hA5, "b_edge0_rise");
        rd(B, 0, DATA, 32'hA5, "b_data0");
        wr(B, 0, EDGE, 32'h05);
        rd(B, 0, EDGE, 32'hA0, "b_edge0_partial_w1c");
        wr(B, 0, EDGE, 32'hFFFF_FFFF);
        rd(B, 0, EDGE, 32'h0,  "b_edge0_wide_w1c");
        in_b[7:0] = 8'h00;
        idle(6);
        rd(B, 0, EDGE, 32'hA5, "b_edge0_fall");
        rd(B, 0, DATA, 32'h0,  "b_data0_low");
        in_b[15:8] = 8'h3C;
        idle(6);
        rd(B, 1, EDGE, 32'h3C, "b_edge1");
        rd(A, 2, EDGE, 32'h0,  "a_unaffected_by_b");

        // reset mid-operation: edges cleared, priming restarts
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(6);
        rd(A, 0, EDGE, 32'h0,         "rereset_edge0");
        rd(A, 0, DATA, 32'hFFFF_FFFF, "rereset_data0");
        rd(A, 4, EDGE, 32'h0,         "rereset_edge4");
        rd(B, 1, EDGE, 32'h0,         "rereset_b_edge1");
        rd(B, 1, DATA, 32'h3C,        "rereset_b_data1");

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
